gearbox_stream_queue: RTL
=========================

Name: gearbox_stream_queue

Overview:
- Runtime-width successor to the multibuffer queue: accepts IN_WIDTH-bit words and returns a contiguous LSB-first bitstream in reads of a per-read selectable length of 1..OUT_WIDTH_MAX/8 bytes.
- Adds flush, byte-accurate fill level, a programmable almost-full threshold and a sticky overflow flag.
- Sits between a wide producer (DMA/bus side) and narrow variable-length consumers (packet/field parsers).

Parameters:
- IN_WIDTH, 128, write word width in bits; must be a multiple of 8.
- OUT_WIDTH_MAX, 48, maximum read width in bits; multiple of 8, and not greater than IN_WIDTH.
- DEPTH_LOG2, 10, word storage depth is 2^DEPTH_LOG2 words.
- LEN_W, 3, width of rd_len; must satisfy 2^LEN_W > OUT_WIDTH_MAX/8.
- LVL_W, derived, bit width of the byte fill level (ceil(log2(total byte capacity))+1).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised externally.
- write_en  in  1  write strobe.
- data_in  in  IN_WIDTH  write word; bit 0 is the earliest stream bit.
- waitrequest  out  1  high means the write in this cycle is not accepted.
- read_en  in  1  read request.
- rd_len  in  LEN_W  bytes to consume on this read, sampled with read_en.
- data_out  out  OUT_WIDTH_MAX  read data, LSB-first; bits at and above rd_len*8 are 0.
- data_valid  out  1  one-cycle pulse qualifying data_out.
- flush  in  1  synchronous discard of all content.
- af_thresh  in  DEPTH_LOG2+1  almost_full when free words <= af_thresh.
- level_bytes  out  LVL_W  total bytes held (words plus residue).
- full  out  1  word storage full.
- almost_full  out  1  see af_thresh.
- empty  out  1  level_bytes == 0.
- overflow  out  1  sticky: a write was attempted while waitrequest was high; cleared by flush or reset.

Behaviour:
- Reset values: all counters and pointers 0; data_out 0, data_valid 0, waitrequest 0, full 0, almost_full 0, empty 1, overflow 0, level_bytes 0.
- Write side:
  - A write is accepted when write_en=1 and waitrequest=0.
  - waitrequest = full, a registered, decoded flag.
  - A simultaneous read never unblocks a write in the same cycle.
- Stream order: word k bit i is stream position k*IN_WIDTH+i. Reads consume strictly in stream order and cross word boundaries seamlessly.
- Read datapath:
  - A residue register of IN_WIDTH+OUT_WIDTH_MAX-8 bits, with a byte count, holds the stream head.
  - Refill rule: when the residue count is below OUT_WIDTH_MAX/8 bytes and storage is non-empty, pop one word from storage. Storage is a 1-cycle synchronous RAM, so the popped word is appended above the residue 1 cycle later.
- Read grant:
  - Condition: read_en=1, rd_len in 1..OUT_WIDTH_MAX/8, and residue count >= rd_len.
  - Response: data_out is registered and data_valid=1 in the next cycle. Residue shifts right by rd_len*8 and its count drops by rd_len.
- Read not granted:
  - Causes: insufficient residue, or an illegal rd_len (0 or > OUT_WIDTH_MAX/8).
  - Response: data_valid=0 next cycle, no state consumed, data_out holds its last value.
- Latency:
  - Write accepted into an empty queue at cycle N: empty falls at N+1.
  - A read at N+3 or later is granted.
- Throughput: back-to-back full-width reads every cycle are sustained while storage is non-empty.
- Level and flags:
  - level_bytes = words*IN_WIDTH/8 + residue count + any in-flight popped word; it updates 1 cycle after each event.
  - Simultaneous write and read update level by +IN_WIDTH/8 - rd_len in a single step.
- Wrap-around: read and write pointers are DEPTH_LOG2+1 bits; full and empty are derived from the MSB comparison; wrap is seamless.
- Flush:
  - Takes priority over a write and a read in the same cycle; both are dropped.
  - Next cycle, outputs match the reset values except data_out, which holds its last value.
- Reset mid-operation: all content is lost immediately and outputs go to their reset values asynchronously.
- af_thresh may change at any time; almost_full reflects it 1 cycle later.

Decomposition:
- Package gearbox_stream_pkg holds:
  - IN_BYTES and OUT_BYTES_MAX constants;
  - an rd_len legality function;
  - a residue-width localparam.
- One sub-module, gbq_word_ram: simple dual-port synchronous RAM, 2^DEPTH_LOG2 x IN_WIDTH, 1-cycle read.
- Pointer, flag and residue logic stays in the top level.

Test Plan:
- Basic: write 3 words (384 bits) of a known pattern, wait 3 cycles, then 8 reads with rd_len=6 -> the 8 consecutive 48-bit slices in order. After that, empty=1, level_bytes=0.
- Mixed length: same 3 words, read rd_len 1,2,3,4,5,6 repeatedly until 48 bytes are consumed -> each data_out matches the stream slice, upper bits 0, final level_bytes=0.
- Underflow/abort: 1 word held (16 B); 32 read attempts with rd_len=6 alternated with idle cycles consume 12 B and stall with 4 B left. The stalled read shows data_valid=0, level_bytes stays 4, and the next data is unchanged. Also read with rd_len=0 and rd_len=7 -> data_valid=0, no consumption.
- Full: write 1024+residue-capacity words with af_thresh=4 -> almost_full rises at 1020 stored words, full and waitrequest follow. The extra write is dropped and overflow=1. A full drain returns exactly the accepted words.
- Concurrent: a writer at 1 word every 3 cycles and a reader issuing rd_len=6 every cycle run for 4096 words -> the stream is intact with no loss or duplication, and the pointers wrap 4 times.
- Flush/reset: flush mid-burst with write_en and read_en also high -> next cycle empty=1, level 0, overflow 0. Assert rst_n low asynchronously mid-read -> outputs go to reset values before the next edge.

Source files
------------

// File: rtl/gearbox_stream_pkg.sv
// gearbox_stream_pkg: shared constants and helpers for the gearbox stream queue
//   IN_BYTES / OUT_BYTES_MAX : default write-word and maximum read sizes in bytes
//   DEPTH_LOG2_DEF / LEN_W_DEF: default storage depth and rd_len width
//   res_width()              : residue register width for a given word/read width
//   len_ok()                 : legality of a requested read length
package gearbox_stream_pkg;

    localparam int IN_BYTES       = 16;
    localparam int OUT_BYTES_MAX  = 6;
    localparam int DEPTH_LOG2_DEF = 10;
    localparam int LEN_W_DEF      = 3;

    function automatic int res_width(input int in_w, input int out_w);
        return in_w + out_w - 8;
    endfunction

    localparam int RES_WIDTH = res_width(IN_BYTES * 8, OUT_BYTES_MAX * 8);

    function automatic logic len_ok(input int len, input int max_bytes);
        return len >= 1 && len <= max_bytes;
    endfunction

endpackage

// File: rtl/gbq_word_ram.sv
// gbq_word_ram: simple dual-port synchronous word RAM with 1-cycle read latency
//   clk     : clock
//   we_i    : write enable, waddr_i / wdata_i : write address / data
//   re_i    : read enable,  raddr_i           : read address
//   rdata_o : read data, valid the cycle after re_i
module gbq_word_ram #(
    parameter int WIDTH = 128,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gearbox_stream_queue.sv
// gearbox_stream_queue: wide-word write, variable-length (1..OUT_WIDTH_MAX/8 byte) LSB-first stream read queue
//   write side : write_en, data_in, waitrequest (= full)
//   read side  : read_en, rd_len -> data_out, data_valid (one cycle later)
//   control    : flush (sync discard), af_thresh (almost_full when free words <= af_thresh)
//   status     : level_bytes, full, almost_full, empty, overflow (sticky)
module gearbox_stream_queue
    import gearbox_stream_pkg::*;
#(
    parameter int IN_WIDTH      = IN_BYTES * 8,
    parameter int OUT_WIDTH_MAX = OUT_BYTES_MAX * 8,
    parameter int DEPTH_LOG2    = DEPTH_LOG2_DEF,
    parameter int LEN_W         = LEN_W_DEF,
    parameter int LVL_W         = $clog2((2**DEPTH_LOG2) * (IN_WIDTH / 8) + res_width(IN_WIDTH, OUT_WIDTH_MAX) / 8) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write_en,
    input  logic [IN_WIDTH-1:0]      data_in,
    output logic                     waitrequest,
    input  logic                     read_en,
    input  logic [LEN_W-1:0]         rd_len,
    output logic [OUT_WIDTH_MAX-1:0] data_out,
    output logic                     data_valid,
    input  logic                     flush,
    input  logic [DEPTH_LOG2:0]      af_thresh,
    output logic [LVL_W-1:0]         level_bytes,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int IB = IN_WIDTH / 8;
    localparam int OB = OUT_WIDTH_MAX / 8;
    localparam int RW = res_width(IN_WIDTH, OUT_WIDTH_MAX);
    localparam int CW = $clog2(RW / 8 + 1);
    localparam int PW = DEPTH_LOG2 + 1;

    logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d, words_d;
    logic [RW-1:0]            res_q, res_d, comb;
    logic [CW-1:0]            cnt_q, cnt_d, eff, len;
    logic                     pend_q, pend_d;
    logic [OUT_WIDTH_MAX-1:0] dout_q, dout_d, mask;
    logic                     dv_q, dv_d, full_q, full_d, af_q, af_d, ovf_q, ovf_d;
    logic [LVL_W-1:0]         lvl_q, lvl_d;
    logic [IN_WIDTH-1:0]      ram_rdata;
    logic                     wr, grant, pop;

    gbq_word_ram #(
        .WIDTH (IN_WIDTH),
        .AW    (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr),
        .waddr_i (wptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (data_in),
        .re_i    (pop),
        .raddr_i (rptr_q[DEPTH_LOG2-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        len     = CW'(rd_len);
        // A word popped last cycle is merged above the residue in the same cycle
        // it arrives, so it is already readable; this keeps full-width reads
        // back-to-back with only OUT_WIDTH_MAX-8 bits of spare residue.
        eff     = cnt_q + (pend_q ? CW'(IB) : '0);
        comb    = res_q | (pend_q ? (RW'(ram_rdata) << {cnt_q, 3'b000}) : '0);
        wr      = write_en && !full_q && !flush;
        grant   = read_en && !flush && len_ok(int'(rd_len), OB) && eff >= len;
        mask    = ~({OUT_WIDTH_MAX{1'b1}} << {rd_len, 3'b000});
        dout_d  = grant ? comb[OUT_WIDTH_MAX-1:0] & mask : dout_q;
        dv_d    = grant;
        res_d   = flush ? '0 : grant ? comb >> {rd_len, 3'b000} : comb;
        cnt_d   = flush ? '0 : eff - (grant ? len : '0);
        // Refill only once the head drops below one full read, so the next
        // arriving word always fits in the residue.
        pop     = !flush && cnt_d < CW'(OB) && wptr_q != rptr_q;
        pend_d  = pop;
        wptr_d  = flush ? '0 : wptr_q + PW'(wr);
        rptr_d  = flush ? '0 : rptr_q + PW'(pop);
        words_d = wptr_d - rptr_d;
        full_d  = wptr_d[DEPTH_LOG2] != rptr_d[DEPTH_LOG2] && wptr_d[DEPTH_LOG2-1:0] == rptr_d[DEPTH_LOG2-1:0];
        af_d    = !flush && (PW'(2**DEPTH_LOG2) - words_d) <= af_thresh;
        ovf_d   = !flush && (ovf_q || (write_en && full_q));
        lvl_d   = LVL_W'(words_d) * LVL_W'(IB) + LVL_W'(cnt_d) + (pend_d ? LVL_W'(IB) : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            dout_q <= '0;
            dv_q   <= 1'b0;
            full_q <= 1'b0;
            af_q   <= 1'b0;
            ovf_q  <= 1'b0;
            lvl_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            res_q  <= res_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
            full_q <= full_d;
            af_q   <= af_d;
            ovf_q  <= ovf_d;
            lvl_q  <= lvl_d;
        end
    end

    assign waitrequest = full_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;
    assign data_out    = dout_q;
    assign data_valid  = dv_q;
    assign level_bytes = lvl_q;
    assign empty       = lvl_q == '0;

endmodule
